// File: rtl/heat_source_selector_pkg.sv
// heat_source_selector_pkg: shared source codes and controller state encoding
package heat_source_selector_pkg;
  typedef enum logic [1:0] {SRC_NONE = 2'd0, SRC_SOLAR = 2'd1, SRC_AMBIENT = 2'd2, SRC_GEO = 2'd3} src_e;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_OPEN = 2'd1, ST_RUN = 2'd2, ST_STOP = 2'd3} state_e;
endpackage

// File: rtl/heat_source_selector_dwell_timer.sv
// dwell_timer: loadable down-counter saturating at zero, shared by all timed states
module dwell_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] val_i,
  output logic             zero_o
);
  logic [CNT_W-1:0] cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else if (load_i) cnt_q <= val_i;
    else if (en_i && cnt_q != '0) cnt_q <= cnt_q - 1'b1;
  assign zero_o = cnt_q == '0;
endmodule

// File: rtl/heat_source_selector.sv
// heat_source_selector: picks a heat/cool loop source from latched samples and sequences valve and pump
module heat_source_selector
  import heat_source_selector_pkg::*;
#(
  parameter int VALVE_SETTLE  = 1000,
  parameter int PUMP_SPINDOWN = 500,
  parameter int MIN_DWELL     = 5000,
  parameter int CNT_W         = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_valid,
  input  logic              heat_req,
  input  logic              cool_req,
  input  logic [15:0]       solar_level,
  input  logic signed [7:0] solar_temp,
  input  logic signed [7:0] ambient_temp,
  input  logic signed [7:0] geothermal_temp,
  input  logic [15:0]       solar_th,
  input  logic signed [7:0] solar_cooldown_th,
  input  logic signed [7:0] solar_heatup_th,
  input  logic signed [7:0] ambient_cooldown_th,
  input  logic signed [7:0] ambient_heatup_th,
  input  logic signed [7:0] geothermal_cooldown_th,
  input  logic signed [7:0] geothermal_heatup_th,
  output logic [1:0]        valve_sel,
  output logic              pump_on,
  output logic              busy
);
  localparam logic [CNT_W-1:0] VS_L = CNT_W'(VALVE_SETTLE - 1);
  localparam logic [CNT_W-1:0] PS_L = CNT_W'(PUMP_SPINDOWN - 1);
  localparam logic [CNT_W-1:0] MD_L = CNT_W'(MIN_DWELL - 1);
  logic [15:0]       level_q;
  logic signed [7:0] solar_q, ambient_q, geo_q;
  logic              heat_q, cool_q;
  state_e            state_q;
  src_e              valve_q, cand;
  logic              pump_q, s_ok, a_ok, g_ok, t_load, t_en, t_zero;
  logic [CNT_W-1:0]  t_val;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      level_q   <= '0;
      solar_q   <= '0;
      ambient_q <= '0;
      geo_q     <= '0;
      heat_q    <= 1'b0;
      cool_q    <= 1'b0;
    end else if (sample_valid) begin
      level_q   <= solar_level;
      solar_q   <= solar_temp;
      ambient_q <= ambient_temp;
      geo_q     <= geothermal_temp;
      heat_q    <= heat_req;
      cool_q    <= cool_req;
    end
  // cooling wants a loop colder than its threshold, heating one strictly warmer
  always_comb begin
    s_ok = level_q >= solar_th && (cool_q ? solar_q < solar_cooldown_th : solar_q > solar_heatup_th);
    a_ok = cool_q ? ambient_q < ambient_cooldown_th : ambient_q > ambient_heatup_th;
    g_ok = cool_q ? geo_q < geothermal_cooldown_th : geo_q > geothermal_heatup_th;
    cand = !(heat_q ^ cool_q) ? SRC_NONE : s_ok ? SRC_SOLAR : a_ok ? SRC_AMBIENT : g_ok ? SRC_GEO : SRC_NONE;
  end
  always_comb begin
    t_load = (state_q == ST_IDLE && cand != SRC_NONE) ||
             (state_q == ST_OPEN && cand != SRC_NONE && (cand != valve_q || t_zero)) ||
             (state_q == ST_RUN && cand != valve_q && t_zero);
    t_val  = state_q == ST_RUN ? PS_L : (state_q == ST_OPEN && cand == valve_q) ? MD_L : VS_L;
    t_en   = state_q != ST_IDLE;
  end
  dwell_timer #(.CNT_W(CNT_W)) u_timer (
    .clk   (clk),
    .rst_n (rst),
    .load_i(t_load),
    .en_i  (t_en),
    .val_i (t_val),
    .zero_o(t_zero)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= ST_IDLE;
      valve_q <= SRC_NONE;
      pump_q  <= 1'b0;
    end else
      case (state_q)
        ST_IDLE: if (cand != SRC_NONE) begin
          valve_q <= cand;
          state_q <= ST_OPEN;
        end
        ST_OPEN: if (cand == SRC_NONE) begin
          valve_q <= SRC_NONE;
          state_q <= ST_IDLE;
        end else if (cand != valve_q) valve_q <= cand;
        else if (t_zero) begin
          pump_q  <= 1'b1;
          state_q <= ST_RUN;
        end
        ST_RUN: if (cand != valve_q && t_zero) begin
          pump_q  <= 1'b0;
          state_q <= ST_STOP;
        end
        ST_STOP: if (t_zero) begin
          valve_q <= SRC_NONE;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          valve_q <= SRC_NONE;
          pump_q  <= 1'b0;
        end
      endcase
  assign valve_sel = valve_q;
  assign pump_on   = pump_q;
  assign busy      = state_q != ST_IDLE;
endmodule

// File: tb/tb_heat_source_selector.sv
// tb_heat_source_selector: directed scenarios plus random samples against a timestamp-based reference model
module tb_heat_source_selector;
  localparam int VS = 4, PS = 3, MD = 8;
  logic clk = 1'b0, rst = 1'b0, sample_valid = 1'b0, heat_req = 1'b0, cool_req = 1'b0;
  logic [15:0] solar_level = '0, s_th = 16'd2550;
  logic signed [7:0] solar_temp = '0, ambient_temp = '0, geothermal_temp = '0;
  logic signed [7:0] s_cd = 8'sd35, s_hu = 8'sd16, a_cd = 8'sd35, a_hu = 8'sd16, g_cd = 8'sd35, g_hu = 8'sd16;
  logic [1:0] valve_sel;
  logic pump_on, busy;
  int n_chk = 0, n_err = 0;
  int cyc = 0, m_ph = 0, m_v = 0, m_p = 0, m_due = 0;
  int l_lvl = 0, l_st = 0, l_at = 0, l_gt = 0, l_h = 0, l_c = 0;
  int pv = 0, pp = 0;
  heat_source_selector #(.VALVE_SETTLE(VS), .PUMP_SPINDOWN(PS), .MIN_DWELL(MD), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .heat_req(heat_req), .cool_req(cool_req),
    .solar_level(solar_level), .solar_temp(solar_temp), .ambient_temp(ambient_temp),
    .geothermal_temp(geothermal_temp), .solar_th(s_th),
    .solar_cooldown_th(s_cd), .solar_heatup_th(s_hu),
    .ambient_cooldown_th(a_cd), .ambient_heatup_th(a_hu),
    .geothermal_cooldown_th(g_cd), .geothermal_heatup_th(g_hu),
    .valve_sel(valve_sel), .pump_on(pump_on), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", tag, got, exp, cyc);
    end
  endtask
  function automatic int cand_f();
    bit sok, aok, gok;
    if (l_h == l_c) return 0;
    sok = l_lvl >= int'(s_th) && (l_c != 0 ? l_st < int'(s_cd) : l_st > int'(s_hu));
    aok = l_c != 0 ? l_at < int'(a_cd) : l_at > int'(a_hu);
    gok = l_c != 0 ? l_gt < int'(g_cd) : l_gt > int'(g_hu);
    return sok ? 1 : aok ? 2 : gok ? 3 : 0;
  endfunction
  task automatic model_reset();
    m_ph = 0; m_v = 0; m_p = 0;
    l_lvl = 0; l_st = 0; l_at = 0; l_gt = 0; l_h = 0; l_c = 0;
  endtask
  // phases: 0 idle, 1 settling, 2 pumping, 3 spinning down; m_due is the first cycle a timed exit is allowed
  task automatic model_step();
    int c;
    cyc++;
    c = cand_f();
    if (m_ph == 0) begin
      if (c != 0) begin m_v = c; m_due = cyc + VS; m_ph = 1; end
    end else if (m_ph == 1) begin
      if (c == 0) begin m_v = 0; m_ph = 0; end
      else if (c != m_v) begin m_v = c; m_due = cyc + VS; end
      else if (cyc >= m_due) begin m_p = 1; m_due = cyc + MD; m_ph = 2; end
    end else if (m_ph == 2) begin
      if (c != m_v && cyc >= m_due) begin m_p = 0; m_due = cyc + PS; m_ph = 3; end
    end else if (cyc >= m_due) begin
      m_v = 0; m_ph = 0;
    end
    if (sample_valid) begin
      l_lvl = int'(solar_level); l_st = int'(solar_temp); l_at = int'(ambient_temp);
      l_gt = int'(geothermal_temp); l_h = int'(heat_req); l_c = int'(cool_req);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    if (!rst) model_reset(); else model_step();
    @(negedge clk);
    chk("valve", valve_sel, m_v);
    chk("pump", pump_on, m_p);
    chk("busy", busy, m_ph != 0);
    if (pump_on) chk("pump_needs_valve", valve_sel != 0, 1);
    if (pp != 0 && pump_on) chk("valve_stable_while_pumping", valve_sel, pv);
    pv = valve_sel; pp = pump_on;
  endtask
  task automatic sample(input bit h, input bit c, input int lvl, input int st, input int at, input int gt);
    heat_req = h; cool_req = c; solar_level = 16'(lvl);
    solar_temp = 8'(st); ambient_temp = 8'(at); geothermal_temp = 8'(gt);
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
  endtask
  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 200) begin tick(); n++; end
    chk(tag, busy, 0);
  endtask
  initial begin
    int n;
    repeat (2) tick();
    chk("reset_valve", valve_sel, 0);
    chk("reset_pump", pump_on, 0);
    chk("reset_busy", busy, 0);
    rst = 1'b1;
    tick();
    // heating from solar: valve two edges after strobe, pump VS cycles later
    sample(1, 0, 3000, 40, 0, 0);
    chk("t2_valve_latch", valve_sel, 0);
    tick();
    chk("t2_valve", valve_sel, 1);
    repeat (3) tick();
    chk("t2_pump_settling", pump_on, 0);
    tick();
    chk("t2_pump", pump_on, 1);
    sample(0, 0, 3000, 40, 0, 0);
    wait_idle("t2_idle");
    // solar below light threshold falls through to ambient
    sample(1, 0, 2500, 40, 20, 0);
    tick();
    chk("t3_valve", valve_sel, 2);
    sample(0, 0, 2500, 40, 20, 0);
    wait_idle("t3_idle");
    // cooling on geothermal, then ambient becomes eligible mid-dwell
    sample(0, 1, 3000, 40, 40, 30);
    tick();
    chk("t4_valve", valve_sel, 3);
    repeat (4) tick();
    chk("t4_pump", pump_on, 1);
    tick();
    sample(0, 1, 3000, 40, 30, 30);
    repeat (3) tick();
    chk("t4_dwell_pump", pump_on, 1);
    chk("t4_dwell_valve", valve_sel, 3);
    n = 0;
    while (pump_on && n < 50) begin tick(); n++; end
    chk("t4_pump_off", pump_on, 0);
    chk("t4_valve_held", valve_sel, 3);
    repeat (2) tick();
    chk("t4_spindown", valve_sel, 3);
    tick();
    chk("t4_valve_closed", valve_sel, 0);
    tick();
    chk("t4_new_valve", valve_sel, 2);
    repeat (4) tick();
    chk("t4_new_pump", pump_on, 1);
    // asynchronous reset while pumping
    #2 rst = 1'b0;
    #1;
    chk("t1_async_pump", pump_on, 0);
    chk("t1_async_valve", valve_sel, 0);
    chk("t1_async_busy", busy, 0);
    model_reset();
    pv = 0; pp = 0;
    tick();
    rst = 1'b1;
    repeat (4) tick();
    chk("t1_stays_idle", valve_sel, 0);
    // contradictory demand selects nothing
    sample(1, 1, 3000, 40, 40, 40);
    repeat (3) tick();
    chk("t5_valve", valve_sel, 0);
    chk("t5_busy", busy, 0);
    // demand drops before settle completes
    sample(1, 0, 3000, 40, 0, 0);
    tick();
    chk("t6_valve", valve_sel, 1);
    tick();
    sample(0, 0, 3000, 40, 0, 0);
    chk("t6_no_pump", pump_on, 0);
    tick();
    chk("t6_valve_closed", valve_sel, 0);
    chk("t6_pump_never", pump_on, 0);
    // strict heat compare: solar_temp equal to threshold is not eligible
    sample(1, 0, 3000, 16, 20, 0);
    tick();
    chk("t6_boundary", valve_sel, 2);
    sample(0, 0, 3000, 16, 20, 0);
    wait_idle("t6_idle");
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        s_hu = 8'(int'($urandom_range(0, 40)) - 5);
        a_cd = 8'(int'($urandom_range(10, 50)));
        s_th = 16'($urandom_range(2450, 2650));
      end
      if ($urandom_range(0, 7) == 0)
        sample($urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0, int'($urandom_range(2400, 2700)),
               int'($urandom_range(0, 60)) - 10, int'($urandom_range(0, 60)) - 10, int'($urandom_range(0, 60)) - 10);
      else tick();
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
